// File: rtl/seven_seg_pkg.sv
// ---------------------------------------------------------------------------
// seven_seg_pkg
// Shared constants for the multiplexed seven-segment scanner:
//   - FONT      : 16-entry hex font, active-high, bit 0 = segment a .. bit 6 = g
//   - SEG_A..G  : bit positions of the segments inside the 8-bit CA bus
//   - SEG_DP    : bit position of the decimal point inside CA
//   - drive_level(): maps a logical "on" to the pin level for a given polarity
// ---------------------------------------------------------------------------
package seven_seg_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Glyphs 0-9 and A, b, C, d, E, F.
  localparam logic [6:0] FONT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Pin level for a signal that is logically "on" when active is 1.
  function automatic logic drive_level(input logic active, input logic active_low);
    return active ^ active_low;
  endfunction

endpackage

// File: rtl/seven_seg_font.sv
// ---------------------------------------------------------------------------
// seven_seg_font
// Combinational hex-to-seven-segment decoder (active-high segments).
//   nibble_i [3:0] : hex digit to display
//   seg_o    [6:0] : segments g..a, 1 = lit
// ---------------------------------------------------------------------------
module seven_seg_font (
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);
  import seven_seg_pkg::*;

  assign seg_o = FONT[nibble_i];

endmodule

// File: rtl/seven_seg_scan.sv
// ---------------------------------------------------------------------------
// seven_seg_scan
// Time-multiplexed driver for NUM_DIGITS seven-segment digits with PWM
// dimming, leading-zero blanking and per-frame snapshot of the display data.
//   CLK, RST_N  : clock, synchronous active-low reset
//   VALUE       : hex nibbles, VALUE[3:0] = digit 0
//   DP          : decimal point per digit (active-high)
//   DIGIT_EN    : per-digit enable (0 = dark)
//   BLANK_LZ    : 1 = blank leading zeros
//   BRIGHT      : on-time (BRIGHT+1)/16 of each digit slot
//   AN          : digit strobes, AN[i] drives digit i
//   CA          : segments a..g in bits 0..6, dp in bit 7
//   FRAME_TICK  : one-cycle pulse after each frame wrap
// A digit slot is DIV_COUNT cycles: 16 PWM phases of DIV_COUNT/16 cycles each.
// ---------------------------------------------------------------------------
module seven_seg_scan #(
  parameter int unsigned NUM_DIGITS       = 8,
  parameter int unsigned DIV_COUNT        = 65536,
  parameter bit          ANODE_ACTIVE_LOW = 1'b1,
  parameter bit          SEG_ACTIVE_LOW   = 1'b1
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic [4*NUM_DIGITS-1:0]   VALUE,
  input  logic [NUM_DIGITS-1:0]     DP,
  input  logic [NUM_DIGITS-1:0]     DIGIT_EN,
  input  logic                      BLANK_LZ,
  input  logic [3:0]                BRIGHT,
  output logic [NUM_DIGITS-1:0]     AN,
  output logic [7:0]                CA,
  output logic                      FRAME_TICK
);
  import seven_seg_pkg::*;

  localparam int unsigned SUB_COUNT = DIV_COUNT / 16;
  localparam int unsigned SUB_W     = (SUB_COUNT > 1) ? $clog2(SUB_COUNT) : 1;
  localparam int unsigned IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SUB_COUNT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF = {NUM_DIGITS{ANODE_ACTIVE_LOW}};
  localparam logic [7:0]            CA_OFF = {8{SEG_ACTIVE_LOW}};

  // Scan counters.
  logic [SUB_W-1:0] sub_q,   sub_d;
  logic [3:0]       phase_q, phase_d;
  logic [IDX_W-1:0] idx_q,   idx_d;
  logic             first_q;  // first cycle after reset release
  logic             sub_wrap, slot_end, frame_end;

  // Frame snapshot and per-slot brightness.
  logic [4*NUM_DIGITS-1:0] value_q;
  logic [NUM_DIGITS-1:0]   dp_q, en_q;
  logic                    blank_lz_q;
  logic [3:0]              bright_q;

  // Registered outputs.
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [7:0]            ca_q, ca_d;
  logic                  frame_tick_q;

  logic [NUM_DIGITS-1:0] lz_blank;
  logic                  above_msd;
  logic [3:0]            cur_nibble;
  logic [6:0]            font_seg;
  logic [7:0]            seg_on;
  logic                  lit;

  assign sub_wrap  = (sub_q == SUB_LAST);
  assign slot_end  = sub_wrap && (phase_q == 4'hF);
  assign frame_end = slot_end && (idx_q == IDX_LAST);

  // Next-state logic for the scan counters.
  always_comb begin
    // NOTE: every output of a combinational block gets a default up front so
    // no path leaves it unassigned, which would infer a latch.
    sub_d   = sub_q + SUB_W'(1);
    phase_d = phase_q;
    idx_d   = idx_q;
    if (sub_wrap) begin
      sub_d   = '0;
      phase_d = phase_q + 4'd1;
    end
    if (slot_end) begin
      idx_d = frame_end ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Leading-zero mask: scanning down from the top digit, a digit stays
  // blankable until the first nonzero nibble is met. Digit 0 never blanks.
  always_comb begin
    lz_blank  = '0;
    above_msd = 1'b1;
    for (int i = int'(NUM_DIGITS) - 1; i > 0; i--) begin
      if (value_q[4*i +: 4] != 4'h0) above_msd = 1'b0;
      lz_blank[i] = above_msd;
    end
  end

  assign cur_nibble = value_q[{idx_q, 2'b00} +: 4];

  seven_seg_font u_font (
    .nibble_i (cur_nibble),
    .seg_o    (font_seg)
  );

  // Output decode from the current counter state; registered below.
  always_comb begin
    lit = (phase_q <= bright_q) && en_q[idx_q] && !(blank_lz_q && lz_blank[idx_q]);

    seg_on              = '0;
    seg_on[SEG_G:SEG_A] = font_seg;
    seg_on[SEG_DP]      = dp_q[idx_q];

    an_d = AN_OFF;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      an_d[i] = drive_level(lit && (idx_q == IDX_W'(i)), ANODE_ACTIVE_LOW);
    end
    ca_d = CA_OFF;
    for (int i = 0; i < 8; i++) begin
      ca_d[i] = drive_level(lit && seg_on[i], SEG_ACTIVE_LOW);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sub_q        <= '0;
      phase_q      <= '0;
      idx_q        <= '0;
      first_q      <= 1'b1;
      // NOTE: the snapshot registers are cleared too, so the cycle right after
      // release decodes as an enabled-nothing frame and the outputs stay dark.
      value_q      <= '0;
      dp_q         <= '0;
      en_q         <= '0;
      blank_lz_q   <= 1'b0;
      bright_q     <= '0;
      an_q         <= AN_OFF;
      ca_q         <= CA_OFF;
      frame_tick_q <= 1'b0;
    end else begin
      sub_q   <= sub_d;
      phase_q <= phase_d;
      idx_q   <= idx_d;
      first_q <= 1'b0;
      // Load at the edge that enters a new slot/frame, so the new values are
      // in place for that slot's/frame's whole duration.
      if (slot_end || first_q) begin
        bright_q <= BRIGHT;
      end
      if (frame_end || first_q) begin
        value_q    <= VALUE;
        dp_q       <= DP;
        en_q       <= DIGIT_EN;
        blank_lz_q <= BLANK_LZ;
      end
      an_q         <= an_d;
      ca_q         <= ca_d;
      frame_tick_q <= frame_end;
    end
  end

  assign AN         = an_q;
  assign CA         = ca_q;
  assign FRAME_TICK = frame_tick_q;

endmodule

// File: doc/seven_seg_scan.md
SEVEN_SEG_SCAN -- requirements
Module: seven_seg_scan

Interface
REQ-001 Parameters SHALL be as follows (name, default, meaning):
- NUM_DIGITS, 8: digits scanned, legal range 1..16.
- DIV_COUNT, 65536: CLK cycles per digit slot; must be a multiple of 16 and at least 16.
- ANODE_ACTIVE_LOW, 1: 1 = AN bits drive low to enable a digit.
- SEG_ACTIVE_LOW, 1: 1 = CA bits drive low to light a segment.

REQ-002 Ports SHALL be as follows (name, direction, width, meaning):
- CLK  in  1: single clock; all logic on its rising edge.
- RST_N  in  1: synchronous, active-low reset.
- VALUE  in  4*NUM_DIGITS: hex nibbles; VALUE[3:0] is digit 0 (least significant).
- DP  in  NUM_DIGITS: decimal point per digit, active-high.
- DIGIT_EN  in  NUM_DIGITS: per-digit enable; 0 = digit dark.
- BLANK_LZ  in  1: 1 = blank leading zeros.
- BRIGHT  in  4: duty in sixteenths; on-time is (BRIGHT+1)/16.
- AN  out  NUM_DIGITS: digit strobes; AN[i] drives digit i.
- CA  out  8: segments; bits 0..6 = a..g, bit 7 = dp.
- FRAME_TICK  out  1: one-cycle pulse at each frame wrap.

Function
REQ-003 Slot timing SHALL use a sub-prescaler counting 0..DIV_COUNT/16-1 and a 4-bit phase counter that advances when the sub-prescaler wraps; the slot ends when phase 15 wraps.
- No derived clocks; every counter is clock-enabled from CLK.
REQ-004 Digit index SHALL advance 0,1,..,NUM_DIGITS-1 at each slot end, then wrap to 0.
REQ-005 At the index wrap to 0, the block SHALL snapshot VALUE, DP, DIGIT_EN and BLANK_LZ into frame registers.
- The displayed content changes only at frame boundaries (no tearing).
- The same snapshot also occurs on the first cycle after reset deassertion.
REQ-006 BRIGHT SHALL be latched at each slot start and used for that whole slot.
REQ-007 The current digit SHALL be lit when phase <= latched BRIGHT, its snapshot DIGIT_EN bit is 1, and it is not leading-zero blanked; otherwise all of AN and CA are inactive.
REQ-008 Leading-zero blanking SHALL dark every digit above the highest nonzero snapshot nibble when snapshot BLANK_LZ = 1.
- Digit 0 is never blanked.
- A digit's DP bit does not prevent it from being blanked.
REQ-009 The font, in active-high form bits g..a, SHALL be:
- 0 = 3F, 1 = 06, 2 = 5B, 3 = 4F, 4 = 66, 5 = 6D, 6 = 7D, 7 = 07
- 8 = 7F, 9 = 67, A = 77, b = 7C, C = 39, d = 5E, E = 79, F = 71
- CA[7] = snapshot DP bit of the current digit.
- Polarity is applied per SEG_ACTIVE_LOW.
REQ-010 When lit, exactly one AN bit (the current index) SHALL be active, with polarity per ANODE_ACTIVE_LOW.
REQ-011 AN, CA and FRAME_TICK SHALL be registered, reflecting the counter state of the previous cycle (one-cycle latency).
REQ-012 FRAME_TICK SHALL be high for exactly one cycle, in the cycle after the index wraps from NUM_DIGITS-1 to 0 (once per NUM_DIGITS*DIV_COUNT cycles).
REQ-013 Input changes outside frame and slot boundaries SHALL have no effect on outputs until the next boundary.

Reset
REQ-014 While RST_N = 0 at a CLK edge, the block SHALL clear all counters, index and snapshots to 0.
- AN and CA go all-inactive (respecting polarity); FRAME_TICK = 0.
REQ-015 Reset asserted mid-slot or mid-frame SHALL take effect on that edge.
- Scanning restarts at digit 0, phase 0 after release.
- Digit 0 output appears on the second cycle after release.

Structure
REQ-016 Package seven_seg_pkg SHALL hold:
- the 16-entry font constant;
- segment bit-index constants (SEG_A..SEG_G, SEG_DP);
- the polarity helper function.
REQ-017 Combinational sub-module seven_seg_font SHALL map a 4-bit nibble to 7 active-high segments; the top level instantiates it once.

Verification
REQ-018 The bench SHALL cover the following, with NUM_DIGITS=4, DIV_COUNT=32, both polarities = 1:
- Scan order: VALUE=0x1234, BRIGHT=15, DIGIT_EN=4'hF, DP=0 -> AN cycles E,D,B,7, each held 32 cycles; CA = ~66, ~4F, ~5B, ~06 (8-bit, dp off); FRAME_TICK every 128 cycles.
- Leading zeros: VALUE=0x0050, BLANK_LZ=1 -> digits 3 and 2 dark; digit 1 CA=~6D, digit 0 CA=~3F. With VALUE=0x0000, only digit 0 lit, showing 0.
- Dimming: BRIGHT=3 -> each digit active 8 of 32 cycles at slot start; BRIGHT=0 -> 2 cycles.
- No tearing: VALUE changed 0x1111 -> 0x2222 while digit 1 is active -> digits 2 and 3 still show 1 this frame; all digits show 2 after the next FRAME_TICK.
- Masking: DIGIT_EN=4'b1011, DP=4'b0001 -> digit 2 dark for its full slot with timing unchanged; digit 0 CA bit 7 = 0.
- Mid-frame reset: RST_N low for one cycle during digit 2 -> next cycle AN=F, CA=FF, FRAME_TICK=0; after release, digit 0 (AN=E) on the second cycle.
